// File: rtl/dmem_bus.sv
// dmem_bus: single-port data memory behind a valid/ready request/response
// bus with configurable wait states, byte/half/word lanes and fault checks.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_size      store/load, 00 byte 01 half 10 word 11 illegal
//   req_signed            sign-extend byte/half loads
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    load data (0 on store/fault), fault flag

module dmem_bus #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [2:0]  WS_LAST = 3'(WAIT_STATES);
   localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic        r_we;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_wcnt;
   logic [31:0] r_rdata;
   logic        r_err;

   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_done;
   logic          w_oob;
   logic          w_misalign;
   logic          w_fault;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;
   logic [31:0]   w_wlane;
   logic [3:0]    w_be;
   logic          w_mem_we;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (req_valid) w_next = S_WAIT;
         S_WAIT:  if (r_wcnt == WS_LAST) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready = (r_state == S_IDLE);
      rsp_valid = (r_state == S_RESP);
      rsp_rdata = r_rdata;
      rsp_err   = r_err;
   end

   assign w_accept = (r_state == S_IDLE) & req_valid;
   // Last WAIT cycle: the memory access happens on this edge.
   assign w_done   = (r_state == S_WAIT) & (r_wcnt == WS_LAST);

   // Wait-state counter, cleared whenever not counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wcnt <= 3'd0;
      end else if ((r_state == S_WAIT) && !w_done) begin
         r_wcnt <= r_wcnt + 3'd1;
      end else begin
         r_wcnt <= 3'd0;
      end
   end

   // Request capture; inputs are ignored outside IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we     <= 1'b0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
      end else if (w_accept) begin
         r_we     <= req_we;
         r_size   <= req_size;
         r_signed <= req_signed;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
      end
   end

   // ---------------- fault detection ----------------
   assign w_oob = (r_addr[31:2] >= DEPTH30);

   always_comb begin
      w_misalign = 1'b0;
      unique case (r_size)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = r_addr[0];
         2'b10:   w_misalign = |r_addr[1:0];
         default: w_misalign = 1'b1;
      endcase
   end

   assign w_fault = w_oob | w_misalign;

   // ---------------- load path ----------------
   assign w_idx  = r_addr[AW+1:2];
   assign w_word = r_mem[w_idx];

   always_comb begin
      w_byte = w_word[7:0];
      unique case (r_addr[1:0])
         2'd0: w_byte = w_word[7:0];
         2'd1: w_byte = w_word[15:8];
         2'd2: w_byte = w_word[23:16];
         2'd3: w_byte = w_word[31:24];
         default: w_byte = w_word[7:0];
      endcase
   end

   assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_load = w_word;
      unique case (r_size)
         2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
         default: w_load = w_word;
      endcase
   end

   // ---------------- store path ----------------
   // Data is replicated across lanes; byte enables pick the target.
   always_comb begin
      w_wlane = r_wdata;
      w_be    = 4'b1111;
      unique case (r_size)
         2'b00: begin
            w_wlane = {4{r_wdata[7:0]}};
            w_be    = 4'b0001 << r_addr[1:0];
         end
         2'b01: begin
            w_wlane = {2{r_wdata[15:0]}};
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            w_wlane = r_wdata;
            w_be    = 4'b1111;
         end
      endcase
   end

   assign w_mem_we = w_done & r_we & ~w_fault;

   // RAM has no reset; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) begin
               r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
            end
         end
      end
   end

   // ---------------- response registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_done) begin
         r_err   <= w_fault;
         r_rdata <= (w_fault | r_we) ? 32'd0 : w_load;
      end
   end

endmodule

// File: tb/tb_dmem_bus.sv
// tb_dmem_bus: self-checking bench for dmem_bus with directed scenarios
// and randomized traffic against a byte-array reference model.

module tb_dmem_bus;

   localparam int DW  = 64;
   localparam int WS  = 1;
   localparam int LAT = WS + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int pass_n  = 0;
   int total_n = 0;

   logic [7:0] mb [0:4*DW-1];

   dmem_bus #(
      .DEPTH_WORDS (DW),
      .WAIT_STATES (WS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic idle_inputs();
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
   endtask

   // One full transaction with rsp_ready high; lat = -1 on timeout.
   task automatic xact(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat);
      int n;
      lat = -1;
      rd  = 'x;
      er  = 1'bx;
      n   = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) return;
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1 idle_inputs();
      n = 1;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) return;
      lat = n;
      rd  = rsp_rdata;
      er  = rsp_err;
      @(posedge clk);
      #1;
   endtask

   // Reference: memory as a little-endian byte array.
   function automatic void ref_access(input logic we, input logic [1:0] sz,
                                      input logic sg, input logic [31:0] a,
                                      input logic [31:0] wd,
                                      output logic [31:0] rd,
                                      output logic er);
      int n;
      logic [31:0] v;
      logic [7:0] bi;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      if (n == 0) er = 1'b1;
      else er = (a >= 32'(4*DW)) || ((a % n) != 0);
      rd = 32'd0;
      if (!er) begin
         if (we) begin
            for (int i = 0; i < n; i++) begin
               bi = 8'(a + 32'(i));
               mb[bi] = 8'(wd >> (8*i));
            end
         end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
               bi = 8'(a + 32'(i));
               v = v | (32'(mb[bi]) << (8*i));
            end
            if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v;
         end
      end
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      total_n++;
      if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready);
      else pass_n++;
      total_n++;
      if (rsp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rsp_valid);
      else pass_n++;
      total_n++;
      if (rsp_rdata !== 32'd0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata);
      else pass_n++;
      total_n++;
      if (rsp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", rsp_err);
      else pass_n++;
      reset = 1'b0;
   endtask

   task automatic test_word();
      logic [31:0] rd;
      logic er;
      int lat;
      xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
      total_n++;
      if (lat !== LAT) $display("FAIL word_st_lat: got %0d want %0d", lat, LAT);
      else pass_n++;
      total_n++;
      if (er !== 1'b0 || rd !== 32'd0) $display("FAIL word_st_rsp: got err=%b rd=%h want 0/0", er, rd);
      else pass_n++;
      xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
      total_n++;
      if (lat !== LAT) $display("FAIL word_ld_lat: got %0d want %0d", lat, LAT);
      else pass_n++;
      total_n++;
      if (er !== 1'b0 || rd !== 32'hDEADBEEF) $display("FAIL word_ld: got err=%b rd=%h want 0/deadbeef", er, rd);
      else pass_n++;
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd;
      logic er;
      int lat;
      xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd, er, lat);
      xact(1'b1, 2'd0, 1'b0, 32'h13, 32'h555555AA, rd, er, lat);
      total_n++;
      if (er !== 1'b0 || lat !== LAT) $display("FAIL byte_st: got err=%b lat=%0d want 0/%0d", er, lat, LAT);
      else pass_n++;
      xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'hAA223344) $display("FAIL byte_merge: got %h want aa223344", rd);
      else pass_n++;
      xact(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'hFFFFFFAA) $display("FAIL byte_sext: got %h want ffffffaa", rd);
      else pass_n++;
      xact(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'h000000AA) $display("FAIL byte_zext: got %h want 000000aa", rd);
      else pass_n++;
   endtask

   task automatic test_half();
      logic [31:0] rd;
      logic er;
      int lat;
      xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h80013344, rd, er, lat);
      xact(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er, lat);
      total_n++;
      if (er !== 1'b0 || rd !== 32'hFFFF8001) $display("FAIL half_sext: got err=%b rd=%h want 0/ffff8001", er, rd);
      else pass_n++;
      xact(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, rd, er, lat);
      total_n++;
      if (er !== 1'b0 || rd !== 32'h00003344) $display("FAIL half_zext: got err=%b rd=%h want 0/00003344", er, rd);
      else pass_n++;
   endtask

   task automatic test_faults();
      logic [31:0] rd;
      logic er;
      int lat;
      logic        f_we [5];
      logic [1:0]  f_sz [5];
      logic [31:0] f_a  [5];
      f_we = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      f_sz = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
      f_a  = '{32'h15, 32'h11, 32'h10, 32'h100, 32'h100};
      xact(1'b1, 2'd2, 1'b0, 32'h00, 32'hA5A5A5A5, rd, er, lat);
      xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h01020304, rd, er, lat);
      xact(1'b1, 2'd2, 1'b0, 32'h14, 32'h05060708, rd, er, lat);
      for (int i = 0; i < 5; i++) begin
         xact(f_we[i], f_sz[i], 1'b0, f_a[i], 32'hFFFFFFFF, rd, er, lat);
         total_n++;
         if (er !== 1'b1 || rd !== 32'd0 || lat !== LAT)
            $display("FAIL fault_%0d: got err=%b rd=%h lat=%0d want 1/0/%0d", i, er, rd, lat, LAT);
         else pass_n++;
      end
      xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'h01020304) $display("FAIL fault_keep10: got %h want 01020304", rd);
      else pass_n++;
      xact(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'h05060708) $display("FAIL fault_keep14: got %h want 05060708", rd);
      else pass_n++;
      xact(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'hA5A5A5A5) $display("FAIL fault_keep00: got %h want a5a5a5a5", rd);
      else pass_n++;
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      logic er;
      int lat;
      int n;
      bit bad;
      xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h13579BDF, rd, er, lat);
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'd2;
      req_addr  = 32'h10;
      @(posedge clk);
      #1 idle_inputs();
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      total_n++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h13579BDF)
         $display("FAIL bp_first: got v=%b rd=%h want 1/13579bdf", rsp_valid, rsp_rdata);
      else pass_n++;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h10;
      req_wdata = 32'hFFFFFFFF;
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h13579BDF ||
             rsp_err !== 1'b0 || req_ready !== 1'b0) bad = 1'b1;
      end
      total_n++;
      if (bad) $display("FAIL bp_hold: got v=%b rd=%h rdy=%b want stable 1/13579bdf/0", rsp_valid, rsp_rdata, req_ready);
      else pass_n++;
      idle_inputs();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'h13579BDF) $display("FAIL bp_ignored: got %h want 13579bdf", rd);
      else pass_n++;
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] rd;
      logic er;
      int lat;
      bit seen;
      xact(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      #1;
      total_n++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL rw_async: got rdy=%b v=%b want 1/0", req_ready, rsp_valid);
      else pass_n++;
      #1 reset = 1'b0;
      @(negedge clk);
      total_n++;
      if (req_ready !== 1'b1) $display("FAIL rw_ready: got %b want 1", req_ready);
      else pass_n++;
      seen = 1'b0;
      repeat (5) begin
         if (rsp_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      total_n++;
      if (seen) $display("FAIL rw_norsp: got rsp_valid=1 want 0");
      else pass_n++;
      xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'hCAFEF00D) $display("FAIL rw_nowrite: got %h want cafef00d", rd);
      else pass_n++;
   endtask

   task automatic test_reset_in_resp();
      logic [31:0] rd;
      logic er;
      int lat;
      int n;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h24;
      req_wdata = 32'h600DCAFE;
      @(posedge clk);
      #1 idle_inputs();
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      reset = 1'b1;
      #1;
      total_n++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL rr_drop: got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
      else pass_n++;
      #1 reset = 1'b0;
      rsp_ready = 1'b1;
      xact(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, er, lat);
      total_n++;
      if (rd !== 32'h600DCAFE) $display("FAIL rr_kept: got %h want 600dcafe", rd);
      else pass_n++;
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, wd;
      logic er, eer, we, sg;
      logic [1:0] sz;
      int lat;
      for (int w = 0; w < DW; w++) begin
         wd = $urandom;
         ref_access(1'b1, 2'd2, 1'b0, 32'(4*w), wd, erd, eer);
         xact(1'b1, 2'd2, 1'b0, 32'(4*w), wd, rd, er, lat);
         total_n++;
         if (er !== eer || lat !== LAT)
            $display("FAIL rnd_init%0d: got err=%b lat=%0d want %b/%0d", w, er, lat, eer, LAT);
         else pass_n++;
      end
      for (int t = 0; t < 200; t++) begin
         we = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 9) == 0) a = 32'(4*DW) + 32'($urandom_range(0, 1023));
         else a = 32'($urandom_range(0, 4*DW-1));
         wd = $urandom;
         ref_access(we, sz, sg, a, wd, erd, eer);
         xact(we, sz, sg, a, wd, rd, er, lat);
         total_n++;
         if (rd !== erd || er !== eer || lat !== LAT)
            $display("FAIL rnd_%0d: we=%b sz=%0d a=%h got rd=%h err=%b lat=%0d want %h/%b/%0d",
                     t, we, sz, a, rd, er, lat, erd, eer, LAT);
         else pass_n++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      rsp_ready = 1'b1;
      idle_inputs();
      test_reset();
      test_word();
      test_byte_lanes();
      test_half();
      test_faults();
      test_backpressure();
      test_reset_in_wait();
      test_reset_in_resp();
      test_random();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
